pipe_mips32_hazard: RTL and testbench
=====================================

PIPE_MIPS32_HAZARD -- requirements
Module: pipe_mips32_hazard

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  DATA_W, 32, datapath and register width
  IMEM_AW, 10, instruction memory address bits (word-addressed)
  DMEM_AW, 10, data memory address bits (word-addressed)
  FWD_EN, 1, 1 = EX/MEM and MEM/WB forwarding; 0 = stall until the producer writes back
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk  in  1  single core clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  prog_we  in  1  instruction-memory write strobe
  prog_addr  in  IMEM_AW  instruction-memory write address
  prog_data  in  32  instruction word
  dmem_we  in  1  external data-memory write strobe, for bench preload
  dmem_addr  in  DMEM_AW  external data-memory address, shared by write and debug read
  dmem_wdata  in  DATA_W  external data-memory write data
  dmem_rdata  out  DATA_W  combinational read of dmem[dmem_addr]
  dbg_reg_addr  in  5  debug register-file read index
  dbg_reg_data  out  DATA_W  combinational read of Reg[dbg_reg_addr]; 0 for index 0
  pc  out  IMEM_AW  current fetch PC
  halted  out  1  1 after HLT retires
  instret  out  32  count of retired non-bubble instructions; wraps modulo 2^32
  stall_cnt  out  32  count of load-use or no-forward stall cycles; wraps modulo 2^32

Function
REQ-003 Pipeline: five stages (IF, ID, EX, MEM, WB) on clk only, one instruction per cycle when there is no hazard.
REQ-004 Encoding: op [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0] sign-extended to DATA_W.
REQ-005 Opcodes: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101, LW 001000, SW 001001, ADDI 001010, SUBI 001011, SLTI 001100, BNEQZ 001101, BEQZ 001110, HLT 111111; any other opcode executes as a NOP.
REQ-006 SLT and SLTI compare signed and write 1 or 0; MUL writes the low DATA_W bits of the product.
REQ-007 Destinations: R-type writes rd; ADDI, SUBI, SLTI and LW write rt; writes to R0 are discarded and R0 always reads 0.
REQ-008 Memory access: LW/SW address = (rs + imm) truncated to DMEM_AW; SW stores rt; core data-memory reads and writes complete in one cycle.
REQ-009 Register file is write-first: a WB write is visible to an ID read in the same cycle.
REQ-010 Forwarding (FWD_EN=1): EX operands come from EX/MEM ALU result first, then MEM/WB result, then the ID/EX latch; matching is by destination index and excludes R0.
REQ-011 Load-use stall: a consumer in ID whose source register is the rt of an LW in EX stalls 1 cycle. PC and IF/ID hold, a bubble enters EX, and stall_cnt increments.
REQ-012 FWD_EN=0: ID stalls while any older instruction in EX or MEM writes a source register of the ID instruction; stall_cnt increments each stall cycle.
REQ-013 Branch: resolved in EX; condition BEQZ rs==0, BNEQZ rs!=0; target = (branch PC + 1 + imm) mod 2^IMEM_AW.
REQ-014 Taken branch: PC <= target on the next edge and the IF/ID and ID/EX contents become bubbles (2-cycle penalty). A not-taken branch has no penalty.
REQ-015 Squashed instructions never write a register or memory and never count in instret.
REQ-016 Flush beats stall when both occur in the same cycle.
REQ-017 HLT in ID, not flushed that cycle: fetch stops, PC freezes, and IF/ID is squashed thereafter. Instructions older than HLT drain normally.
REQ-018 HLT reaching WB sets halted=1. Once halted, all state freezes until reset, and HLT itself counts in instret.
REQ-019 A flushed HLT has no effect.
REQ-020 PC increments modulo 2^IMEM_AW.
REQ-021 prog_we and dmem_we write on the clk edge regardless of rst_n or halted. On a same-address collision in one cycle, an external dmem write beats a core SW.

Reset
REQ-022 rst_n low asynchronously clears PC, all pipeline latches (to bubbles), halted, instret, stall_cnt and Reg[1..31] to 0.
REQ-023 Reset does not clear instruction or data memory; the program is loaded through prog_we while rst_n is low.
REQ-024 Reset asserted mid-operation aborts all in-flight instructions with no further register or memory writes. Fetch resumes at PC 0 on the first edge after deassertion.

Verification
REQ-025 Back-to-back dependency, FWD_EN=1: ADDI R1,R0,5; ADDI R2,R1,3; ADD R3,R1,R2; HLT -> R3=13, stall_cnt=0, instret=4.
REQ-026 Load-use: dmem[4]=7; LW R1,4(R0); ADD R2,R1,R1; HLT -> R2=14, stall_cnt=1.
REQ-027 Taken branch: ADDI R1,R0,0; BEQZ R1,+2; ADDI R2,R0,9; ADDI R3,R0,9; ADDI R4,R0,1; HLT -> R2=0, R3=0, R4=1, instret=4.
REQ-028 FWD_EN=0 with the REQ-025 program -> R3=13, stall_cnt>0, identical register results.
REQ-029 Signed compare: ADDI R1,R0,-1; SLTI R2,R1,0; SW R2,8(R0); HLT -> R2=1, dmem[8]=1; R0 write attempt (ADDI R0,R0,3) -> dbg R0 reads 0.
REQ-030 Reset mid-run: assert rst_n low 3 cycles into a store loop -> outputs zeroed, no store after assertion, and restart reproduces the full-run result.

Source files
------------

// File: rtl/pipe_mips32_hazard.sv
// -----------------------------------------------------------------------------
// pipe_mips32_hazard
// Five-stage (IF, ID, EX, MEM, WB) in-order MIPS-like core.
// Hazards are handled by forwarding or by stalling, selected with FWD_EN.
// Taken branches resolve in EX, HLT stops fetch, and the core freezes once
// HLT retires.
//
// Parameters
//   DATA_W   datapath / register width
//   IMEM_AW  instruction memory address bits (word addressed)
//   DMEM_AW  data memory address bits (word addressed)
//   FWD_EN   1 = EX/MEM and MEM/WB forwarding with a one-cycle load-use
//            stall; 0 = no forwarding, ID stalls until the producer is in WB
//
// Ports
//   clk, rst_n            core clock (rising edge), async active-low reset
//   prog_we/addr/data     instruction memory load port
//   dmem_we/addr/wdata    external data memory write port
//   dmem_rdata            combinational read of dmem[dmem_addr]
//   dbg_reg_addr/data     combinational register file read (R0 reads 0)
//   pc                    current fetch PC
//   halted                set when HLT retires
//   instret               retired non-bubble instruction count
//   stall_cnt             hazard stall cycle count
// -----------------------------------------------------------------------------
module pipe_mips32_hazard #(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 10,
    parameter int DMEM_AW = 10,
    parameter int FWD_EN  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prog_we,
    input  logic [IMEM_AW-1:0] prog_addr,
    input  logic [31:0]        prog_data,
    input  logic               dmem_we,
    input  logic [DMEM_AW-1:0] dmem_addr,
    input  logic [DATA_W-1:0]  dmem_wdata,
    output logic [DATA_W-1:0]  dmem_rdata,
    input  logic [4:0]         dbg_reg_addr,
    output logic [DATA_W-1:0]  dbg_reg_data,
    output logic [IMEM_AW-1:0] pc,
    output logic               halted,
    output logic [31:0]        instret,
    output logic [31:0]        stall_cnt
);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam bit FWD_ON = (FWD_EN != 0);

    // ---------------------------------------------------------------- storage
    logic [31:0]       imem [0:(2**IMEM_AW)-1];
    logic [DATA_W-1:0] dmem [0:(2**DMEM_AW)-1];
    logic [DATA_W-1:0] regs [0:31];

    // ------------------------------------------------------- pipeline state
    logic [IMEM_AW-1:0] pc_reg;
    logic               halted_reg;
    logic               fetch_stop_reg;
    logic [31:0]        instret_reg;
    logic [31:0]        stall_cnt_reg;

    logic               ifid_valid_reg;
    logic [31:0]        ifid_ir_reg;
    logic [IMEM_AW-1:0] ifid_pc_reg;

    logic               idex_valid_reg;
    logic [5:0]         idex_op_reg;
    logic [4:0]         idex_rs_reg;
    logic [4:0]         idex_rt_reg;
    logic [4:0]         idex_dest_reg;
    logic               idex_wen_reg;
    logic [DATA_W-1:0]  idex_a_reg;
    logic [DATA_W-1:0]  idex_b_reg;
    logic [DATA_W-1:0]  idex_imm_reg;
    logic [IMEM_AW-1:0] idex_pc_reg;

    logic               exmem_valid_reg;
    logic [5:0]         exmem_op_reg;
    logic [4:0]         exmem_dest_reg;
    logic               exmem_wen_reg;
    logic [DATA_W-1:0]  exmem_alu_reg;
    logic [DATA_W-1:0]  exmem_b_reg;

    logic               memwb_valid_reg;
    logic [5:0]         memwb_op_reg;
    logic [4:0]         memwb_dest_reg;
    logic               memwb_wen_reg;
    logic [DATA_W-1:0]  memwb_result_reg;

    // ------------------------------------------------------------ ID decode
    logic [5:0]         id_op;
    logic [4:0]         id_rs;
    logic [4:0]         id_rt;
    logic [4:0]         id_rd;
    logic [DATA_W-1:0]  id_imm;
    logic               id_is_r;
    logic               id_wr_rt;
    logic [4:0]         id_dest;
    logic               id_wen;
    logic               id_use_rs;
    logic               id_use_rt;
    logic [DATA_W-1:0]  id_a;
    logic [DATA_W-1:0]  id_b;
    logic               wb_we;

    logic               hit_idex;
    logic               hit_exmem;
    logic               load_use;
    logic               nofwd_haz;
    logic               id_stall;
    logic               id_hlt_go;

    // ------------------------------------------------------------ EX / MEM
    logic [DATA_W-1:0]  ex_a;
    logic [DATA_W-1:0]  ex_b;
    logic [DATA_W-1:0]  ex_alu;
    logic               ex_taken;
    logic [IMEM_AW-1:0] ex_target;
    logic [DMEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0]  mem_result;
    logic               mem_store;

    assign pc        = pc_reg;
    assign halted    = halted_reg;
    assign instret   = instret_reg;
    assign stall_cnt = stall_cnt_reg;

    assign dmem_rdata   = dmem[dmem_addr];
    assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? '0 : regs[dbg_reg_addr];

    // Register writes happen only from a live WB slot; R0 is never flagged
    // as a destination, so it can never be written.
    assign wb_we = memwb_valid_reg && memwb_wen_reg && !halted_reg;

    always_comb begin
        id_op     = ifid_ir_reg[31:26];
        id_rs     = ifid_ir_reg[25:21];
        id_rt     = ifid_ir_reg[20:16];
        id_rd     = ifid_ir_reg[15:11];
        id_imm    = {{(DATA_W-16){ifid_ir_reg[15]}}, ifid_ir_reg[15:0]};
        id_is_r   = (id_op <= OP_MUL);
        id_wr_rt  = (id_op == OP_LW) || (id_op == OP_ADDI) ||
                    (id_op == OP_SUBI) || (id_op == OP_SLTI);
        id_dest   = id_is_r ? id_rd : id_rt;
        id_wen    = (id_is_r || id_wr_rt) && (id_dest != 5'd0);
        id_use_rs = id_is_r || id_wr_rt || (id_op == OP_SW) ||
                    (id_op == OP_BNEQZ) || (id_op == OP_BEQZ);
        id_use_rt = id_is_r || (id_op == OP_SW);

        // Write-first register file: a same-cycle WB write bypasses the array.
        if (id_rs == 5'd0)
            id_a = '0;
        else if (wb_we && (memwb_dest_reg == id_rs))
            id_a = memwb_result_reg;
        else
            id_a = regs[id_rs];

        if (id_rt == 5'd0)
            id_b = '0;
        else if (wb_we && (memwb_dest_reg == id_rt))
            id_b = memwb_result_reg;
        else
            id_b = regs[id_rt];
    end

    // --------------------------------------------------------- hazard logic
    always_comb begin
        hit_idex  = idex_valid_reg && idex_wen_reg &&
                    ((id_use_rs && (idex_dest_reg == id_rs)) ||
                     (id_use_rt && (idex_dest_reg == id_rt)));
        hit_exmem = exmem_valid_reg && exmem_wen_reg &&
                    ((id_use_rs && (exmem_dest_reg == id_rs)) ||
                     (id_use_rt && (exmem_dest_reg == id_rt)));
        load_use  = FWD_ON && hit_idex && (idex_op_reg == OP_LW);
        nofwd_haz = !FWD_ON && (hit_idex || hit_exmem);
        id_stall  = ifid_valid_reg && (load_use || nofwd_haz);
        // A HLT sitting in ID only takes effect if the branch in EX is not
        // throwing it away this cycle.
        id_hlt_go = ifid_valid_reg && (id_op == OP_HLT) && !ex_taken;
    end

    // ------------------------------------------------------ EX: forwarding
    // EX/MEM has priority over MEM/WB because it holds the younger producer.
    // A load in EX/MEM is never forwarded from here: the load-use stall
    // guarantees the consumer only reaches EX once the load is in MEM/WB.
    always_comb begin
        if (FWD_ON && exmem_valid_reg && exmem_wen_reg && (exmem_dest_reg == idex_rs_reg))
            ex_a = exmem_alu_reg;
        else if (FWD_ON && memwb_valid_reg && memwb_wen_reg && (memwb_dest_reg == idex_rs_reg))
            ex_a = memwb_result_reg;
        else
            ex_a = idex_a_reg;

        if (FWD_ON && exmem_valid_reg && exmem_wen_reg && (exmem_dest_reg == idex_rt_reg))
            ex_b = exmem_alu_reg;
        else if (FWD_ON && memwb_valid_reg && memwb_wen_reg && (memwb_dest_reg == idex_rt_reg))
            ex_b = memwb_result_reg;
        else
            ex_b = idex_b_reg;
    end

    always_comb begin
        ex_alu = '0;
        case (idex_op_reg)
            OP_ADD:                  ex_alu = ex_a + ex_b;
            OP_SUB:                  ex_alu = ex_a - ex_b;
            OP_AND:                  ex_alu = ex_a & ex_b;
            OP_OR:                   ex_alu = ex_a | ex_b;
            OP_SLT:                  ex_alu = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
            OP_MUL:                  ex_alu = ex_a * ex_b;
            OP_LW, OP_SW, OP_ADDI:   ex_alu = ex_a + idex_imm_reg;
            OP_SUBI:                 ex_alu = ex_a - idex_imm_reg;
            OP_SLTI:                 ex_alu = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(idex_imm_reg))};
            default:                 ex_alu = '0;
        endcase
    end

    assign ex_taken  = idex_valid_reg &&
                       (((idex_op_reg == OP_BEQZ)  && (ex_a == '0)) ||
                        ((idex_op_reg == OP_BNEQZ) && (ex_a != '0)));
    assign ex_target = idex_pc_reg + IMEM_AW'(1) + idex_imm_reg[IMEM_AW-1:0];

    // ------------------------------------------------------------------ MEM
    assign mem_addr   = exmem_alu_reg[DMEM_AW-1:0];
    assign mem_result = (exmem_op_reg == OP_LW) ? dmem[mem_addr] : exmem_alu_reg;
    assign mem_store  = exmem_valid_reg && (exmem_op_reg == OP_SW) && !halted_reg;

    // ------------------------------------------------------------- memories
    // Memories have no reset so a program survives reset. The external
    // dmem write comes second so it wins an address collision.
    always_ff @(posedge clk) begin
        if (prog_we)
            imem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (mem_store)
            dmem[mem_addr] <= exmem_b_reg;
        if (dmem_we)
            dmem[dmem_addr] <= dmem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (wb_we) begin
            regs[memwb_dest_reg] <= memwb_result_reg;
        end
    end

    // ------------------------------------------------------ pipeline update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg           <= '0;
            halted_reg       <= 1'b0;
            fetch_stop_reg   <= 1'b0;
            instret_reg      <= '0;
            stall_cnt_reg    <= '0;
            ifid_valid_reg   <= 1'b0;
            ifid_ir_reg      <= '0;
            ifid_pc_reg      <= '0;
            idex_valid_reg   <= 1'b0;
            idex_op_reg      <= '0;
            idex_rs_reg      <= '0;
            idex_rt_reg      <= '0;
            idex_dest_reg    <= '0;
            idex_wen_reg     <= 1'b0;
            idex_a_reg       <= '0;
            idex_b_reg       <= '0;
            idex_imm_reg     <= '0;
            idex_pc_reg      <= '0;
            exmem_valid_reg  <= 1'b0;
            exmem_op_reg     <= '0;
            exmem_dest_reg   <= '0;
            exmem_wen_reg    <= 1'b0;
            exmem_alu_reg    <= '0;
            exmem_b_reg      <= '0;
            memwb_valid_reg  <= 1'b0;
            memwb_op_reg     <= '0;
            memwb_dest_reg   <= '0;
            memwb_wen_reg    <= 1'b0;
            memwb_result_reg <= '0;
        end else if (!halted_reg) begin
            // PC: taken branch first, then hold for stall / halt, else advance.
            if (ex_taken)
                pc_reg <= ex_target;
            else if (!(id_stall || fetch_stop_reg || id_hlt_go))
                pc_reg <= pc_reg + IMEM_AW'(1);

            if (id_hlt_go)
                fetch_stop_reg <= 1'b1;

            if (id_stall && !ex_taken)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;

            // IF/ID: flush and HLT squash beat the stall hold.
            if (ex_taken || fetch_stop_reg || id_hlt_go) begin
                ifid_valid_reg <= 1'b0;
            end else if (!id_stall) begin
                ifid_valid_reg <= 1'b1;
                ifid_ir_reg    <= imem[pc_reg];
                ifid_pc_reg    <= pc_reg;
            end

            // ID/EX: bubble on flush or stall.
            idex_valid_reg <= ifid_valid_reg && !ex_taken && !id_stall;
            idex_op_reg    <= id_op;
            idex_rs_reg    <= id_rs;
            idex_rt_reg    <= id_rt;
            idex_dest_reg  <= id_dest;
            idex_wen_reg   <= id_wen;
            idex_a_reg     <= id_a;
            idex_b_reg     <= id_b;
            idex_imm_reg   <= id_imm;
            idex_pc_reg    <= ifid_pc_reg;

            exmem_valid_reg <= idex_valid_reg;
            exmem_op_reg    <= idex_op_reg;
            exmem_dest_reg  <= idex_dest_reg;
            exmem_wen_reg   <= idex_wen_reg;
            exmem_alu_reg   <= ex_alu;
            exmem_b_reg     <= ex_b;

            memwb_valid_reg  <= exmem_valid_reg;
            memwb_op_reg     <= exmem_op_reg;
            memwb_dest_reg   <= exmem_dest_reg;
            memwb_wen_reg    <= exmem_wen_reg;
            memwb_result_reg <= mem_result;

            if (memwb_valid_reg) begin
                instret_reg <= instret_reg + 32'd1;
                if (memwb_op_reg == OP_HLT)
                    halted_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_mips32_hazard.sv
// -----------------------------------------------------------------------------
// tb_pipe_mips32_hazard
// Runs small programs on two copies of the core (forwarding and stall-only)
// driven from the same program/data ports. Expected architectural results are
// queued when each program is loaded and compared once both cores halt.
// -----------------------------------------------------------------------------
module tb_pipe_mips32_hazard;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam int K_REG     = 0;
    localparam int K_MEM     = 1;
    localparam int K_INSTRET = 2;
    localparam int K_STALL   = 3;
    localparam int K_PC      = 4;
    localparam int K_STALLNZ = 5;

    localparam int D_FWD   = 0;
    localparam int D_NOFWD = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [9:0]  prog_addr;
    logic [31:0] prog_data;
    logic        dmem_we;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic [4:0]  dbg_reg_addr;

    logic [31:0] f_dmem_rdata, n_dmem_rdata;
    logic [31:0] f_dbg, n_dbg;
    logic [9:0]  f_pc, n_pc;
    logic        f_halted, n_halted;
    logic [31:0] f_instret, n_instret;
    logic [31:0] f_stall, n_stall;

    always #5 clk = ~clk;

    pipe_mips32_hazard #(.DATA_W(32), .IMEM_AW(10), .DMEM_AW(10), .FWD_EN(1)) u_fwd (
        .clk(clk), .rst_n(rst_n),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(f_dmem_rdata),
        .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(f_dbg),
        .pc(f_pc), .halted(f_halted), .instret(f_instret), .stall_cnt(f_stall)
    );

    pipe_mips32_hazard #(.DATA_W(32), .IMEM_AW(10), .DMEM_AW(10), .FWD_EN(0)) u_nofwd (
        .clk(clk), .rst_n(rst_n),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(n_dmem_rdata),
        .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(n_dbg),
        .pc(n_pc), .halted(n_halted), .instret(n_instret), .stall_cnt(n_stall)
    );

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] val;
        int          dut;
    } exp_t;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } pre_t;

    exp_t        sb[$];
    pre_t        pre_q[$];
    logic [31:0] prog_q[$];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] r_ins(logic [5:0] op, int rd, int rs, int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] i_ins(logic [5:0] op, int rt, int rs, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic push(input string tag, input int kind, input int idx,
                        input logic [31:0] val, input int dut);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        e.dut  = dut;
        sb.push_back(e);
    endtask

    // Same expectation for both cores.
    task automatic push2(input string tag, input int kind, input int idx, input logic [31:0] val);
        push({tag, "_f"}, kind, idx, val, D_FWD);
        push({tag, "_n"}, kind, idx, val, D_NOFWD);
    endtask

    task automatic observe(input exp_t e, output logic [31:0] v);
        v = '0;
        case (e.kind)
            K_REG: begin
                dbg_reg_addr = 5'(e.idx);
                #1;
                v = (e.dut == D_FWD) ? f_dbg : n_dbg;
            end
            K_MEM: begin
                dmem_addr = 10'(e.idx);
                #1;
                v = (e.dut == D_FWD) ? f_dmem_rdata : n_dmem_rdata;
            end
            K_INSTRET: v = (e.dut == D_FWD) ? f_instret : n_instret;
            K_STALL:   v = (e.dut == D_FWD) ? f_stall : n_stall;
            K_PC:      v = (e.dut == D_FWD) ? {22'd0, f_pc} : {22'd0, n_pc};
            K_STALLNZ: v = {31'd0, ((e.dut == D_FWD) ? f_stall : n_stall) != 32'd0};
            default:   v = '0;
        endcase
    endtask

    // Hold reset, write the program and data preload, leave reset asserted.
    task automatic load_program();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < prog_q.size(); i++) begin
            prog_we   = 1'b1;
            prog_addr = 10'(i);
            prog_data = prog_q[i];
            @(posedge clk);
            #1;
        end
        prog_we = 1'b0;
        for (int i = 0; i < pre_q.size(); i++) begin
            dmem_we    = 1'b1;
            dmem_addr  = pre_q[i].a;
            dmem_wdata = pre_q[i].d;
            @(posedge clk);
            #1;
        end
        dmem_we = 1'b0;
        @(posedge clk);
        #1;
        prog_q.delete();
        pre_q.delete();
    endtask

    task automatic run_and_drain(input string name);
        exp_t        e;
        logic [31:0] v;
        int          cyc;
        rst_n = 1'b1;
        cyc   = 0;
        while (!(f_halted && n_halted) && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, "_halt"}, {31'd0, f_halted & n_halted}, 32'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            observe(e, v);
            check(e.tag, v, e.val);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        prog_we      = 1'b0;
        prog_addr    = '0;
        prog_data    = '0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        dbg_reg_addr = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pc",      {22'd0, f_pc}, 32'd0);
        check("rst_halted",  {31'd0, f_halted}, 32'd0);
        check("rst_instret", f_instret, 32'd0);
        check("rst_stall",   f_stall, 32'd0);

        // Back-to-back dependencies.
        prog_q = '{i_ins(OP_ADDI, 1, 0, 5), i_ins(OP_ADDI, 2, 1, 3),
                   r_ins(OP_ADD, 3, 1, 2), {OP_HLT, 26'd0}};
        push2("dep_r1", K_REG, 1, 32'd5);
        push2("dep_r2", K_REG, 2, 32'd8);
        push2("dep_r3", K_REG, 3, 32'd13);
        push2("dep_instret", K_INSTRET, 0, 32'd4);
        push2("dep_pc", K_PC, 0, 32'd4);
        push("dep_stall_f", K_STALL, 0, 32'd0, D_FWD);
        push("dep_stallnz_n", K_STALLNZ, 0, 32'd1, D_NOFWD);
        load_program();
        run_and_drain("dep");

        // Load-use.
        pre_q.push_back('{a: 10'd4, d: 32'd7});
        prog_q = '{i_ins(OP_LW, 1, 0, 4), r_ins(OP_ADD, 2, 1, 1), {OP_HLT, 26'd0}};
        push2("ldu_r1", K_REG, 1, 32'd7);
        push2("ldu_r2", K_REG, 2, 32'd14);
        push2("ldu_instret", K_INSTRET, 0, 32'd3);
        push("ldu_stall_f", K_STALL, 0, 32'd1, D_FWD);
        load_program();
        run_and_drain("ldu");

        // Taken branch squashes two instructions.
        prog_q = '{i_ins(OP_ADDI, 1, 0, 0), i_ins(OP_BEQZ, 0, 1, 2),
                   i_ins(OP_ADDI, 2, 0, 9), i_ins(OP_ADDI, 3, 0, 9),
                   i_ins(OP_ADDI, 4, 0, 1), {OP_HLT, 26'd0}};
        push2("br_r2", K_REG, 2, 32'd0);
        push2("br_r3", K_REG, 3, 32'd0);
        push2("br_r4", K_REG, 4, 32'd1);
        push2("br_instret", K_INSTRET, 0, 32'd4);
        push2("br_pc", K_PC, 0, 32'd6);
        push("br_stall_f", K_STALL, 0, 32'd0, D_FWD);
        load_program();
        run_and_drain("br");

        // Signed compare, store, R0 write attempt.
        pre_q.push_back('{a: 10'd8, d: 32'h55});
        prog_q = '{i_ins(OP_ADDI, 1, 0, -1), i_ins(OP_SLTI, 2, 1, 0),
                   i_ins(OP_SW, 2, 0, 8), i_ins(OP_ADDI, 0, 0, 3), {OP_HLT, 26'd0}};
        push2("slt_r1", K_REG, 1, 32'hffff_ffff);
        push2("slt_r2", K_REG, 2, 32'd1);
        push2("slt_r0", K_REG, 0, 32'd0);
        push2("slt_m8", K_MEM, 8, 32'd1);
        push2("slt_instret", K_INSTRET, 0, 32'd5);
        load_program();
        run_and_drain("slt");

        // R-type mix with a negative operand.
        prog_q = '{i_ins(OP_ADDI, 1, 0, 6), i_ins(OP_ADDI, 2, 0, -3),
                   r_ins(OP_MUL, 3, 1, 2), r_ins(OP_SUB, 4, 1, 2),
                   r_ins(OP_AND, 5, 1, 2), r_ins(OP_OR, 6, 1, 2),
                   r_ins(OP_SLT, 7, 2, 1), i_ins(OP_SUBI, 8, 1, 10), {OP_HLT, 26'd0}};
        push2("mix_mul", K_REG, 3, 32'hffff_ffee);
        push2("mix_sub", K_REG, 4, 32'd9);
        push2("mix_and", K_REG, 5, 32'd4);
        push2("mix_or",  K_REG, 6, 32'hffff_ffff);
        push2("mix_slt", K_REG, 7, 32'd1);
        push2("mix_subi", K_REG, 8, 32'hffff_fffc);
        push2("mix_instret", K_INSTRET, 0, 32'd9);
        load_program();
        run_and_drain("mix");

        // Store loop aborted by reset, then rerun to completion.
        for (int i = 16; i <= 20; i++)
            pre_q.push_back('{a: 10'(i), d: 32'd0});
        prog_q = '{i_ins(OP_ADDI, 1, 0, 4), i_ins(OP_SW, 1, 1, 16),
                   i_ins(OP_SUBI, 1, 1, 1), i_ins(OP_BNEQZ, 0, 1, -3), {OP_HLT, 26'd0}};
        load_program();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_pc_f",      {22'd0, f_pc}, 32'd0);
        check("mrst_pc_n",      {22'd0, n_pc}, 32'd0);
        check("mrst_instret_f", f_instret, 32'd0);
        check("mrst_stall_f",   f_stall, 32'd0);
        check("mrst_halted_f",  {31'd0, f_halted}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 17; i <= 20; i++) begin
            dmem_addr = 10'(i);
            #1;
            check($sformatf("mrst_nostore_m%0d", i), f_dmem_rdata, 32'd0);
        end
        dbg_reg_addr = 5'd1;
        #1;
        check("mrst_r1_f", f_dbg, 32'd0);
        for (int i = 17; i <= 20; i++)
            push2($sformatf("loop_m%0d", i), K_MEM, i, 32'(i - 16));
        push2("loop_r1", K_REG, 1, 32'd0);
        push2("loop_instret", K_INSTRET, 0, 32'd14);
        push2("loop_pc", K_PC, 0, 32'd5);
        push("loop_stall_f", K_STALL, 0, 32'd0, D_FWD);
        run_and_drain("loop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
